number_multiplication_seq: RTL and testbench

- Sequential radix-2 shift-and-add unsigned multiplier, the multiplicative counterpart of the team's combinational divider.
- Used in the ADPLL datapath to rebuild frequency words: tuning word = ratio × reference, and to undo divider scaling.
- Takes one operand pair per transaction over a valid/ready handshake and returns a full-width product plus a truncated WIDTH-bit result with an overflow flag.
- Fixed latency, so loop-timing analysis stays deterministic.

---
 rtl/adpll_arith_pkg.sv | 29 ++
 rtl/mul_step.sv | 24 ++
 rtl/number_multiplication_seq.sv | 136 +++++++++++++
 tb/tb_number_multiplication_seq.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/adpll_arith_pkg.sv
// Shared definitions for the ADPLL arithmetic blocks (divider/multiplier pair).
//
// Handshake rules shared by both blocks:
//   - An operand pair is taken on the rising edge where in_valid && in_ready.
//   - in_ready is high only in IDLE. The source need not hold the operands
//     after that edge, because the block has already latched them.
//   - A result is presented with out_valid. It stays stable until the edge
//     where out_valid && out_ready.
//   - Result ports keep their last value after acceptance. Only out_valid
//     qualifies them.
//
// Contents:
//   mul_state_t    - FSM states of the sequential multiplier
//   mul_cnt_width  - width of the step counter for a given operand width
package adpll_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    // Counter must reach WIDTH-1 without wrapping. $clog2 gives exactly that.
    // The counter is clamped to at least one bit so it stays a legal vector.
    function automatic int mul_cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/mul_step.sv
// One radix-2 shift-and-add step. The block is purely combinational, so an
// unrolled or pipelined multiplier can reuse it.
//
// Ports:
//   i_acc        - running partial-product sum (2*WIDTH)
//   i_mcand      - multiplicand, already shifted to this step's weight (2*WIDTH)
//   i_mplier_bit - multiplier bit for this step
//   o_acc_next   - i_acc + i_mcand when the bit is set, otherwise i_acc
//   o_mcand_next - i_mcand shifted left by one for the next step
module mul_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [2*WIDTH-1:0] i_mcand,
    input  logic               i_mplier_bit,
    output logic [2*WIDTH-1:0] o_acc_next,
    output logic [2*WIDTH-1:0] o_mcand_next
);

    // The sum never exceeds (2^WIDTH-1)^2, so a 2*WIDTH-bit add cannot overflow.
    assign o_acc_next   = i_mplier_bit ? (i_acc + i_mcand) : i_acc;
    assign o_mcand_next = {i_mcand[2*WIDTH-2:0], 1'b0};

endmodule

// File: rtl/number_multiplication_seq.sv
// Sequential radix-2 shift-and-add unsigned multiplier for the ADPLL datapath.
// Latency is fixed: WIDTH+1 cycles from the accept edge to out_valid.
// Throughput is one result per WIDTH+2 cycles.
//
// Ports:
//   clk       - system clock; all state updates on the rising edge
//   rst_n     - asynchronous, active-low reset
//   in_valid  - operand pair A/B is valid
//   in_ready  - block can accept an operand pair (high only in IDLE)
//   A, B      - unsigned multiplicand / multiplier (WIDTH)
//   out_valid - result valid; held until out_ready
//   out_ready - consumer accepts the result
//   Prod      - full product A*B (2*WIDTH)
//   Res       - Prod[WIDTH-1:0]
//   Ovf       - high when the upper half of Prod is non-zero
module number_multiplication_seq
    import adpll_arith_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   Prod,
    output logic [WIDTH-1:0]     Res,
    output logic                 Ovf
);

    localparam int CNT_W = mul_cnt_width(WIDTH);

    mul_state_t          r_state;
    mul_state_t          w_state_next;

    logic [2*WIDTH-1:0]  r_mcand;
    logic [WIDTH-1:0]    r_mplier;
    logic [2*WIDTH-1:0]  r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic [2*WIDTH-1:0]  r_prod;
    logic                r_ovf;

    logic [2*WIDTH-1:0]  w_acc_next;
    logic [2*WIDTH-1:0]  w_mcand_next;
    logic                w_accept;
    logic                w_last;
    logic                w_release;

    assign w_accept  = in_valid  && (r_state == IDLE);
    assign w_last    = (r_state == BUSY) && (r_cnt == CNT_W'(WIDTH - 1));
    assign w_release = out_ready && (r_state == DONE);

    mul_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_acc        (r_acc),
        .i_mcand      (r_mcand),
        .i_mplier_bit (r_mplier[0]),
        .o_acc_next   (w_acc_next),
        .o_mcand_next (w_mcand_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Handshake outputs are decoded from the state register only, so no
    // input reaches an output combinationally.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (w_accept) begin
                    w_state_next = BUSY;
                end
            end
            BUSY: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (w_release) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_prod   <= '0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_mcand  <= {{WIDTH{1'b0}}, A};
            r_mplier <= B;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (r_state == BUSY) begin
            r_acc    <= w_acc_next;
            r_mcand  <= w_mcand_next;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CNT_W'(1);
            // The result registers load from the last step directly, so they
            // are valid on the first DONE cycle. They keep that value until
            // the next transaction finishes.
            if (w_last) begin
                r_prod <= w_acc_next;
                r_ovf  <= |w_acc_next[2*WIDTH-1:WIDTH];
            end
        end
    end

    assign Prod = r_prod;
    assign Res  = r_prod[WIDTH-1:0];
    assign Ovf  = r_ovf;

endmodule

// File: tb/tb_number_multiplication_seq.sv
module tb_number_multiplication_seq;

    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] Prod;
    logic [W-1:0]   Res;
    logic           Ovf;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    number_multiplication_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Prod      (Prod),
        .Res       (Res),
        .Ovf       (Ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_ready_to"}, 32'(in_ready), 32'd1);
    endtask

    // Accept one pair and wait for the result.
    // lat counts clock edges from the accept edge, inclusive, up to the edge
    // after which out_valid is seen high.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
        A        = a;
        B        = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        A        = 8'hA5;
        B        = 8'h5A;
        lat      = 1;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_vec(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [15:0] exp_prod, input logic exp_ovf);
        int lat;
        wait_ready(tag);
        out_ready = 1'b0;
        launch(a, b, lat);
        check({tag, "_lat"},  32'(lat),  32'(W + 1));
        check({tag, "_prod"}, 32'(Prod), 32'(exp_prod));
        check({tag, "_res"},  32'(Res),  32'(exp_prod[7:0]));
        check({tag, "_ovf"},  32'(Ovf),  32'(exp_ovf));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_vld_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_idle"},     32'(in_ready),  32'd1);
        check({tag, "_retain"},   32'(Prod),      32'(exp_prod));
    endtask

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] p;
    } vec_t;

    vec_t b2b[6];

    initial begin
        int   lat;
        int   prev_cyc;
        int   n;
        logic seen;
        logic held_ok;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        #23;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_prod",      32'(Prod),      32'd0);
        check("rst_ovf",       32'(Ovf),       32'd0);
        rst_n = 1'b1;
        tick();

        // Reset in the middle of BUSY aborts the transaction.
        A        = 8'd100;
        B        = 8'd10;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready",  32'(in_ready),  32'd1);
        check("midrst_prod",      32'(Prod),      32'd0);
        tick();
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            seen |= out_valid;
        end
        check("midrst_no_result", 32'(seen), 32'd0);

        // Directed vectors.
        run_vec("basic",   8'd100, 8'd10,  16'd1000,  1'b1);
        run_vec("a0",      8'd0,   8'd255, 16'd0,     1'b0);
        run_vec("b0",      8'd37,  8'd0,   16'd0,     1'b0);
        run_vec("max",     8'd255, 8'd255, 16'hFE01,  1'b1);
        run_vec("small",   8'd16,  8'd3,   16'd48,    1'b0);
        run_vec("edge255", 8'd15,  8'd17,  16'd255,   1'b0);
        run_vec("edge256", 8'd16,  8'd16,  16'd256,   1'b1);

        // Backpressure. While DONE is held, a new in_valid must be ignored.
        wait_ready("bp");
        out_ready = 1'b0;
        launch(8'd70, 8'd10, lat);
        check("bp_lat",  32'(lat),  32'(W + 1));
        check("bp_prod", 32'(Prod), 32'd700);
        in_valid = 1'b1;
        A        = 8'd5;
        B        = 8'd5;
        held_ok  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (Prod !== 16'd700 || in_ready !== 1'b0 || out_valid !== 1'b1) held_ok = 1'b0;
        end
        check("bp_hold", 32'(held_ok), 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_vld_drop", 32'(out_valid), 32'd0);
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            seen |= out_valid;
        end
        check("bp_ignored_in", 32'(seen), 32'd0);
        run_vec("bp_next", 8'd12, 8'd12, 16'd144, 1'b0);

        // Back-to-back stream with in_valid and out_ready held high.
        b2b[0] = '{8'd3,   8'd7,   16'd21};
        b2b[1] = '{8'd200, 8'd2,   16'd400};
        b2b[2] = '{8'd255, 8'd1,   16'd255};
        b2b[3] = '{8'd1,   8'd255, 16'd255};
        b2b[4] = '{8'd128, 8'd128, 16'd16384};
        b2b[5] = '{8'd15,  8'd17,  16'd255};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        A         = b2b[0].a;
        B         = b2b[0].b;
        prev_cyc  = 0;
        for (int i = 0; i < 6; i++) begin
            wait_ready("b2b");
            tick();
            if (i < 5) begin
                A = b2b[i+1].a;
                B = b2b[i+1].b;
            end else begin
                in_valid = 1'b0;
            end
            n = 1;
            while (!out_valid && n < 50) begin
                tick();
                n++;
            end
            check("b2b_prod", 32'(Prod), 32'(b2b[i].p));
            check("b2b_ovf",  32'(Ovf),  32'(|b2b[i].p[15:8]));
            if (i > 0) check("b2b_interval", 32'(cyc - prev_cyc), 32'(W + 2));
            prev_cyc = cyc;
            tick();
        end
        out_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
